reg_arb: RTL and testbench

- Arbiter and sequencer in front of the single-port 16x8 register file.
- Shares the file between two requesters: the APB slave interface and a fabric-side engine port.
- Serialises their accesses and inserts APB wait states (PREADY low) while the file is busy.
- Flags out-of-range APB addresses with PSLVERR.

---
 rtl/reg_arb_pkg.sv | 21 ++
 rtl/reg_arb_rr_arb2.sv | 28 ++
 rtl/reg_arb.sv | 163 ++++++++++++++++
 tb/tb_reg_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_arb_pkg : shared state/owner encodings and default widths        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package reg_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_APB_AW = 8;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACC  = 2'd1;
  localparam logic [1:0] c_RDW  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic c_OWN_APB = 1'b0;
  localparam logic c_OWN_FAB = 1'b1;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_arb_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2 : combinational two-way round-robin pick (APB vs fabric)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic i_req_apb,
  input  logic i_req_fab,
  input  logic i_last_owner,
  output logic o_valid,
  output logic o_owner
);

  always_comb begin
    o_valid = i_req_apb | i_req_fab;
    o_owner = c_OWN_APB;
    // On a tie the requester that was not served last wins.
    if (i_req_apb && i_req_fab) begin
      o_owner = ~i_last_owner;
    end else if (i_req_fab) begin
      o_owner = c_OWN_FAB;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/reg_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_arb : APB / fabric arbiter and sequencer for a 16x8 register file|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int APB_AW = DEF_APB_AW
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_req_apb;
  logic              w_req_fab;
  logic              w_gnt_valid;
  logic              w_gnt_owner;
  logic              w_apb_oor;
  logic              w_gnt_err;
  logic [ADDR_W-1:0] w_apb_addr;
  logic              w_unused;

  // The setup phase alone is not a request; only the access phase is.
  assign w_req_apb  = PSEL & PENABLE;
  assign w_req_fab  = f_req;
  assign w_apb_addr = PADDR[ADDR_W+1:2];
  assign w_apb_oor  = |PADDR[APB_AW-1:ADDR_W+2];
  assign w_gnt_err  = (w_gnt_owner == c_OWN_APB) & w_apb_oor;
  assign w_unused   = ^PADDR[1:0];

  rr_arb2 u_rr_arb2 (
    .i_req_apb    (w_req_apb),
    .i_req_fab    (w_req_fab),
    .i_last_owner (r_last_owner),
    .o_valid      (w_gnt_valid),
    .o_owner      (w_gnt_owner)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_gnt_valid) begin
          w_next = w_gnt_err ? c_DONE : c_ACC;
        end
      end
      c_ACC:   w_next = r_we ? c_DONE : c_RDW;
      c_RDW:   w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Grant-time latch: later requester input changes do not affect the access.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_owner      <= c_OWN_APB;
      r_last_owner <= c_OWN_FAB;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_gnt_valid) begin
            r_owner <= w_gnt_owner;
            r_err   <= w_gnt_err;
            r_rdata <= '0;
            if (w_gnt_owner == c_OWN_APB) begin
              r_we    <= PWRITE;
              r_addr  <= w_apb_addr;
              r_wdata <= PWDATA;
            end else begin
              r_we    <= f_we;
              r_addr  <= f_addr;
              r_wdata <= f_wdata;
            end
          end
        end
        c_RDW:   r_rdata      <= mem_rdata;
        c_DONE:  r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    f_ack     = 1'b0;
    f_rdata   = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (r_state != c_IDLE);
    case (r_state)
      c_ACC: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_wr_en = r_we;
        mem_rd_en = ~r_we;
      end
      c_DONE: begin
        if (r_owner == c_OWN_APB) begin
          PREADY  = 1'b1;
          PRDATA  = r_rdata;
          PSLVERR = r_err;
        end else begin
          f_ack   = 1'b1;
          f_rdata = r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule : reg_arb
`default_nettype wire

// File: tb/tb_reg_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_arb : directed self-checking bench for reg_arb                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_reg_arb;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0] PADDR = '0, PWDATA = '0, PRDATA;
  logic       PREADY, PSLVERR;
  logic       f_req = 1'b0, f_we = 1'b0, f_ack;
  logic [3:0] f_addr = '0;
  logic [7:0] f_wdata = '0, f_rdata;
  logic       mem_wr_en, mem_rd_en, busy;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] obs;
  assign obs = {busy, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
                PREADY, PSLVERR, PRDATA, f_ack, f_rdata};

  reg_arb dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .f_req(f_req), .f_we(f_we),
    .f_addr(f_addr), .f_wdata(f_wdata), .f_ack(f_ack), .f_rdata(f_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // Register-file model: synchronous write, read data one cycle after strobe.
  logic [7:0] mem [16];
  logic       load_mem = 1'b0;
  always @(posedge PCLK) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hC0 + 8'(i);
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(negedge PCLK);
  endtask

  task automatic apb_idle;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Runs one fabric access (state must be IDLE); lat = negedges to f_ack, -1 on timeout.
  task automatic fab_xfer(input logic we, input logic [3:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    f_req = 1'b1; f_we = we; f_addr = a; f_wdata = d;
    lat = -1; rd = '0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      tick();
      if (f_ack) begin
        lat = i; rd = f_rdata; f_req = 1'b0;
      end
    end
    f_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    PRESET = 1'b1; load_mem = 1'b1;
    repeat (3) tick();
    load_mem = 1'b0;
    n_cmp++; if (obs !== 34'h0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    PRESET = 1'b0;
    tick();
    n_cmp++; if (obs !== 34'h0) begin n_err++; $display("FAIL idle_outputs: got %h want 0", obs); end
  endtask

  task automatic test_apb_write;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h14; PWDATA = 8'hA5;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL setup_not_request: busy got %b want 0", busy); end
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PWDATA = 8'h00; PADDR = 8'h3C;
    tick();
    n_cmp++; if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata, PREADY} !== {1'b1, 1'b0, 4'h5, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL apb_wr_strobe: wr=%b rd=%b addr=%h wdata=%h pready=%b want 1 0 5 a5 0",
                        mem_wr_en, mem_rd_en, mem_addr, mem_wdata, PREADY); end
    tick();
    n_cmp++; if ({PREADY, PSLVERR, PRDATA, mem_wr_en} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL apb_wr_done: pready=%b pslverr=%b prdata=%h wr=%b want 1 0 00 0",
                        PREADY, PSLVERR, PRDATA, mem_wr_en); end
    apb_idle();
    tick();
    n_cmp++; if ({PREADY, busy} !== 2'b00) begin n_err++; $display("FAIL apb_wr_after: pready/busy got %b want 00", {PREADY, busy}); end
  endtask

  task automatic test_apb_read;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h14;
    tick();
    PENABLE = 1'b1;
    tick();
    n_cmp++; if ({mem_wr_en, mem_rd_en, mem_addr, PREADY} !== {1'b0, 1'b1, 4'h5, 1'b0}) begin
      n_err++; $display("FAIL apb_rd_strobe: wr=%b rd=%b addr=%h pready=%b want 0 1 5 0",
                        mem_wr_en, mem_rd_en, mem_addr, PREADY); end
    tick();
    n_cmp++; if ({PREADY, PRDATA, busy} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL apb_rd_wait: pready=%b prdata=%h busy=%b want 0 00 1", PREADY, PRDATA, busy); end
    tick();
    n_cmp++; if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 8'hA5}) begin
      n_err++; $display("FAIL apb_rd_done: pready=%b pslverr=%b prdata=%h want 1 0 a5", PREADY, PSLVERR, PRDATA); end
    apb_idle();
    tick();
    n_cmp++; if ({PREADY, PRDATA} !== 9'h0) begin n_err++; $display("FAIL apb_rd_after: pready/prdata got %h want 0", {PREADY, PRDATA}); end
  endtask

  task automatic test_fab_read;
    f_req = 1'b1; f_we = 1'b0; f_addr = 4'h5;
    tick();
    n_cmp++; if ({mem_rd_en, mem_addr} !== {1'b1, 4'h5}) begin
      n_err++; $display("FAIL fab_rd_strobe: rd=%b addr=%h want 1 5", mem_rd_en, mem_addr); end
    tick();
    n_cmp++; if (f_ack !== 1'b0) begin n_err++; $display("FAIL fab_rd_early_ack: got %b want 0", f_ack); end
    tick();
    n_cmp++; if ({f_ack, f_rdata, PREADY} !== {1'b1, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL fab_rd_done: ack=%b rdata=%h pready=%b want 1 a5 0", f_ack, f_rdata, PREADY); end
    f_req = 1'b0;
    tick();
    n_cmp++; if ({f_ack, f_rdata} !== 9'h0) begin n_err++; $display("FAIL fab_rd_after: ack/rdata got %h want 0", {f_ack, f_rdata}); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp_seq [4];
    int         ns;
    logic       strobe, prev_strobe;
    PRESET = 1'b1;
    tick(); tick();
    PRESET = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 8'h11;
    f_we = 1'b1; f_addr = 4'h2; f_wdata = 8'h22;
    tick();
    PENABLE = 1'b1; f_req = 1'b1;
    tick();
    n_cmp++; if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'h2, 8'h11}) begin
      n_err++; $display("FAIL tie_first_apb: wr=%b addr=%h wdata=%h want 1 2 11", mem_wr_en, mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({PREADY, f_ack} !== 2'b10) begin n_err++; $display("FAIL tie_apb_done: pready/ack got %b want 10", {PREADY, f_ack}); end
    apb_idle();
    tick();
    n_cmp++; if ({busy, f_ack, mem_wr_en} !== 3'b000) begin n_err++; $display("FAIL tie_gap_idle: busy/ack/wr got %b want 000", {busy, f_ack, mem_wr_en}); end
    tick();
    n_cmp++; if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 4'h2, 8'h22}) begin
      n_err++; $display("FAIL tie_second_fab: wr=%b addr=%h wdata=%h want 1 2 22", mem_wr_en, mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({f_ack, PREADY} !== 2'b10) begin n_err++; $display("FAIL tie_fab_done: ack/pready got %b want 10", {f_ack, PREADY}); end
    f_req = 1'b0;
    // Both requesters now hold reads continuously; grants must alternate.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h08;
    f_we = 1'b0; f_addr = 4'h5;
    tick();
    PENABLE = 1'b1; f_req = 1'b1;
    exp_seq[0] = 4'h2; exp_seq[1] = 4'h5; exp_seq[2] = 4'h2; exp_seq[3] = 4'h5;
    ns = 0; prev_strobe = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      strobe = mem_wr_en | mem_rd_en;
      if (strobe) begin
        n_cmp++;
        if (ns >= 4 || mem_addr !== exp_seq[ns]) begin
          n_err++; $display("FAIL alt_grant_%0d: addr got %h want %h", ns, mem_addr, (ns < 4) ? exp_seq[ns] : 4'hx);
        end
        ns++;
      end
      if (strobe && prev_strobe) begin
        n_err++; $display("FAIL alt_back_to_back: strobes in consecutive cycles at step %0d", i);
      end
      if (PREADY) begin
        n_cmp++; if (PRDATA !== 8'h22) begin n_err++; $display("FAIL alt_apb_data: got %h want 22", PRDATA); end
      end else begin
        n_cmp++; if (PRDATA !== 8'h00) begin n_err++; $display("FAIL alt_prdata_forced0: got %h want 00", PRDATA); end
      end
      if (f_ack) begin
        n_cmp++; if (f_rdata !== 8'hA5) begin n_err++; $display("FAIL alt_fab_data: got %h want a5", f_rdata); end
      end
      prev_strobe = strobe;
    end
    apb_idle(); f_req = 1'b0;
    n_cmp++; if (ns != 4) begin n_err++; $display("FAIL alt_grant_count: got %0d want 4", ns); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL alt_drain: busy got %b want 0", busy); end
  endtask

  task automatic test_apb_error;
    logic [7:0] rd;
    int         lat;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h40; PWDATA = 8'hFF;
    tick();
    PENABLE = 1'b1;
    tick();
    n_cmp++; if ({PREADY, PSLVERR, PRDATA, mem_wr_en, mem_rd_en} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL err_done: pready=%b pslverr=%b prdata=%h wr=%b rd=%b want 1 1 00 0 0",
                        PREADY, PSLVERR, PRDATA, mem_wr_en, mem_rd_en); end
    apb_idle();
    tick();
    n_cmp++; if ({PREADY, PSLVERR, busy, mem_wr_en} !== 4'b0000) begin
      n_err++; $display("FAIL err_after: pready/pslverr/busy/wr got %b want 0000", {PREADY, PSLVERR, busy, mem_wr_en}); end
    fab_xfer(1'b0, 4'h0, 8'h00, rd, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL err_readback_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 8'hC0) begin n_err++; $display("FAIL err_mem_unchanged: word0 got %h want c0", rd); end
  endtask

  task automatic test_reset_mid;
    f_req = 1'b1; f_we = 1'b0; f_addr = 4'h5;
    tick();
    tick();
    n_cmp++; if ({busy, mem_rd_en, f_ack} !== 3'b100) begin n_err++; $display("FAIL rst_in_rdw: busy/rd/ack got %b want 100", {busy, mem_rd_en, f_ack}); end
    PRESET = 1'b1;
    tick();
    n_cmp++; if (obs !== 34'h0) begin n_err++; $display("FAIL rst_mid_outputs: got %h want 0", obs); end
    PRESET = 1'b0;
    tick();
    n_cmp++; if ({mem_rd_en, mem_addr, f_ack} !== {1'b1, 4'h5, 1'b0}) begin
      n_err++; $display("FAIL rst_reserve_strobe: rd=%b addr=%h ack=%b want 1 5 0", mem_rd_en, mem_addr, f_ack); end
    tick();
    n_cmp++; if (f_ack !== 1'b0) begin n_err++; $display("FAIL rst_reserve_early_ack: got %b want 0", f_ack); end
    tick();
    n_cmp++; if ({f_ack, f_rdata} !== {1'b1, 8'hA5}) begin
      n_err++; $display("FAIL rst_reserve_done: ack=%b rdata=%h want 1 a5", f_ack, f_rdata); end
    f_req = 1'b0;
    tick();
    n_cmp++; if (f_ack !== 1'b0) begin n_err++; $display("FAIL rst_reserve_after: ack got %b want 0", f_ack); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_v [6];
    logic [7:0] rd;
    int         lat;
    // {mem_wr_en, f_ack, busy} for the six cycles after the first grant.
    exp_v[0] = 3'b101; exp_v[1] = 3'b011; exp_v[2] = 3'b000;
    exp_v[3] = 3'b101; exp_v[4] = 3'b011; exp_v[5] = 3'b000;
    f_req = 1'b1; f_we = 1'b1; f_addr = 4'h7; f_wdata = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if ({mem_wr_en, f_ack, busy} !== exp_v[i]) begin
        n_err++; $display("FAIL b2b_cycle_%0d: wr/ack/busy got %b want %b", i + 1, {mem_wr_en, f_ack, busy}, exp_v[i]); end
      if (i == 4) f_req = 1'b0;
    end
    fab_xfer(1'b0, 4'h7, 8'h00, rd, lat);
    n_cmp++; if ({lat == 3, rd} !== {1'b1, 8'h3C}) begin
      n_err++; $display("FAIL b2b_readback: lat=%0d rdata=%h want 3 3c", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_apb_write();
    test_apb_read();
    test_fab_read();
    test_simultaneous();
    test_apb_error();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_arb
`default_nettype wire
